// File: rtl/ro_sampler.sv
// Ring-oscillator post-processing: gates the oscillator, synchronises and strobes its output,
// debiases with a von Neumann extractor, health-tests raw bits and packs words onto valid/ready.
module ro_sampler #(
  parameter int SAMPLE_DIV = 4,
  parameter int OUT_W      = 8,
  parameter int REP_LIMIT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ro_in,
  output logic             ro_activate,
  output logic [OUT_W-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             fault
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PKC_W = $clog2(OUT_W + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  typedef enum logic {
    VN_EMPTY = 1'b0,
    VN_HOLD  = 1'b1
  } vn_state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  vn_state_t        vn_state_q, vn_state_d;
  logic             vn_bit_q, vn_bit_d;
  logic [OUT_W-1:0] pk_q, pk_d;
  logic [PKC_W-1:0] pk_cnt_q, pk_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             prev_q, prev_d;
  logic             fault_q, fault_d;
  logic             ro_activate_q, ro_activate_d;
  logic [OUT_W-1:0] rnd_data_q, rnd_data_d;
  logic             rnd_valid_q, rnd_valid_d;

  logic             run;
  logic             strobe;
  logic             emit;
  logic             fault_set;
  logic             pk_full;
  logic             load;
  logic [REP_W-1:0] rep_next;

  always_comb begin
    sync1_d       = ro_in;
    sync2_d       = sync1_q;
    div_cnt_d     = div_cnt_q;
    vn_state_d    = vn_state_q;
    vn_bit_d      = vn_bit_q;
    pk_d          = pk_q;
    pk_cnt_d      = pk_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    prev_d        = prev_q;
    fault_d       = fault_q;
    rnd_data_d    = rnd_data_q;
    rnd_valid_d   = rnd_valid_q;
    strobe        = 1'b0;
    emit          = 1'b0;
    fault_set     = 1'b0;
    rep_next      = rep_cnt_q;

    run           = enable & ~fault_q;
    ro_activate_d = run;

    if (run) begin
      if (div_cnt_q == DIV_W'(SAMPLE_DIV - 1)) begin
        strobe    = 1'b1;
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end else begin
      div_cnt_d = '0;
    end

    // rep_cnt==0 marks "no previous sample" so the first strobe always starts a fresh run
    if (strobe) begin
      if ((rep_cnt_q != '0) && (sync2_q == prev_q)) begin
        rep_next = rep_cnt_q + 1'b1;
      end else begin
        rep_next = REP_W'(1);
      end
      rep_cnt_d = rep_next;
      prev_d    = sync2_q;
      fault_set = (rep_next == REP_W'(REP_LIMIT));

      case (vn_state_q)
        VN_EMPTY: begin
          vn_bit_d   = sync2_q;
          vn_state_d = VN_HOLD;
        end
        VN_HOLD: begin
          emit       = (vn_bit_q != sync2_q);
          vn_state_d = VN_EMPTY;
        end
        default: vn_state_d = VN_EMPTY;
      endcase
    end

    pk_full = (pk_cnt_q == PKC_W'(OUT_W));
    load    = run & pk_full & (~rnd_valid_q | rnd_ready);

    if (load) begin
      rnd_data_d  = pk_q;
      rnd_valid_d = 1'b1;
      pk_cnt_d    = '0;
    end else if (rnd_valid_q & rnd_ready) begin
      rnd_valid_d = 1'b0;
    end

    // A bit emitted on the load edge starts the next word; stale upper bits shift out later
    if (emit && (load || !pk_full)) begin
      pk_d     = {pk_q[OUT_W-2:0], vn_bit_q};
      pk_cnt_d = load ? PKC_W'(1) : pk_cnt_q + 1'b1;
    end

    if (!run) begin
      vn_state_d = VN_EMPTY;
      pk_d       = '0;
      pk_cnt_d   = '0;
      rep_cnt_d  = '0;
    end

    if (fault_set) begin
      fault_d     = 1'b1;
      rnd_valid_d = 1'b0;
      vn_state_d  = VN_EMPTY;
      pk_d        = '0;
      pk_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      div_cnt_q     <= '0;
      vn_state_q    <= VN_EMPTY;
      vn_bit_q      <= 1'b0;
      pk_q          <= '0;
      pk_cnt_q      <= '0;
      rep_cnt_q     <= '0;
      prev_q        <= 1'b0;
      fault_q       <= 1'b0;
      ro_activate_q <= 1'b0;
      rnd_data_q    <= '0;
      rnd_valid_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      div_cnt_q     <= div_cnt_d;
      vn_state_q    <= vn_state_d;
      vn_bit_q      <= vn_bit_d;
      pk_q          <= pk_d;
      pk_cnt_q      <= pk_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_q        <= prev_d;
      fault_q       <= fault_d;
      ro_activate_q <= ro_activate_d;
      rnd_data_q    <= rnd_data_d;
      rnd_valid_q   <= rnd_valid_d;
    end
  end

  assign ro_activate = ro_activate_q;
  assign rnd_data    = rnd_data_q;
  assign rnd_valid   = rnd_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ro_sampler.sv
// Bench for ro_sampler: directed vectors on a SAMPLE_DIV=1 instance, randomized stimulus
// on a SAMPLE_DIV=4 instance checked against a queue-based reference model.
module tb_ro_sampler;

  localparam int MD = 4;
  localparam int MW = 8;
  localparam int MR = 16;

  logic clk = 1'b0;
  logic rst_n, enable, ro_in, rnd_ready;
  logic       d1_act, d1_valid, d1_fault;
  logic [7:0] d1_data;
  logic       d4_act, d4_valid, d4_fault;
  logic [7:0] d4_data;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  ro_sampler #(.SAMPLE_DIV(1), .OUT_W(8), .REP_LIMIT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ro_in(ro_in),
    .ro_activate(d1_act), .rnd_data(d1_data), .rnd_valid(d1_valid),
    .rnd_ready(rnd_ready), .fault(d1_fault));

  ro_sampler #(.SAMPLE_DIV(MD), .OUT_W(MW), .REP_LIMIT(MR)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ro_in(ro_in),
    .ro_activate(d4_act), .rnd_data(d4_data), .rnd_valid(d4_valid),
    .rnd_ready(rnd_ready), .fault(d4_fault));

  // Handshake monitor for dut1, sampled mid-cycle where inputs and outputs are stable
  logic [7:0] got[$];
  int         got_cyc[$];
  int         ncyc = 0;
  int         vcnt = 0;
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    vcnt <= vcnt + int'(d1_valid);
    if (rst_n && d1_valid && rnd_ready) begin
      got.push_back(d1_data);
      got_cyc.push_back(ncyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] gw(input int i);
    if (i < got.size()) return {1'b0, got[i]};
    return 9'h1FF;
  endfunction

  function automatic int gc(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -100;
  endfunction

  // Stimulus queue for hand-written sequences
  bit q_ro[$];
  task automatic push_vec(input logic [63:0] v, input int len);
    for (int i = 0; i < len; i++) q_ro.push_back(v[len-1-i]);
  endtask
  task automatic push_fill(input int n);
    for (int i = 0; i < n; i++) q_ro.push_back((i % 4) >= 2);
  endtask

  // Reference model: raw samples become pairs, pairs become a bit list, full lists become words
  bit         m_sync[$];
  int         m_ticks, m_runlen;
  bit         m_last, m_valid, m_fault, m_act;
  bit         m_pair[$];
  bit         m_bits[$];
  logic [7:0] m_data;

  function automatic void m_reset();
    m_sync = '{1'b0, 1'b0};
    m_ticks = 0; m_runlen = 0; m_last = 1'b0;
    m_valid = 1'b0; m_fault = 1'b0; m_act = 1'b0;
    m_pair.delete(); m_bits.delete();
    m_data = 8'h00;
  endfunction

  function automatic void m_step(input bit en, input bit ro, input bit rdy);
    bit s2, run, strobe, emit, ebit, fset, can_load;
    logic [7:0] w;
    s2 = m_sync[0];
    void'(m_sync.pop_front());
    m_sync.push_back(ro);
    run = en && !m_fault;
    strobe = 1'b0; emit = 1'b0; ebit = 1'b0; fset = 1'b0;
    if (run) begin
      m_ticks++;
      strobe = (m_ticks % MD) == 0;
    end
    if (strobe) begin
      m_runlen = (m_runlen > 0 && s2 == m_last) ? m_runlen + 1 : 1;
      m_last = s2;
      fset = (m_runlen >= MR);
      m_pair.push_back(s2);
      if (m_pair.size() == 2) begin
        emit = (m_pair[0] != m_pair[1]);
        ebit = m_pair[0];
        m_pair.delete();
      end
    end
    can_load = run && (m_bits.size() == MW) && (!m_valid || rdy);
    if (fset) begin
      m_fault = 1'b1; m_valid = 1'b0;
      m_bits.delete(); m_pair.delete();
    end else if (!run) begin
      m_ticks = 0; m_runlen = 0;
      m_pair.delete(); m_bits.delete();
      if (m_valid && rdy) m_valid = 1'b0;
    end else begin
      if (can_load) begin
        w = 8'h00;
        for (int i = 0; i < MW; i++) w[MW-1-i] = m_bits[i];
        m_data = w; m_valid = 1'b1;
        m_bits.delete();
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (emit && m_bits.size() < MW) m_bits.push_back(ebit);
    end
    m_act = run;
  endfunction

  typedef struct {
    logic [63:0] vec;
    int          len;
    int          nw;
    logic [7:0]  w0;
    logic [7:0]  w1;
  } vec_t;

  vec_t tbl[7];

  // Streams vec (MSB first) with enable raised two cycles in so raw bit k aligns with strobe k
  task automatic run_vec(input int idx, input vec_t t);
    int  v0;
    bit  pad;
    got.delete(); got_cyc.delete();
    v0 = vcnt;
    rnd_ready = 1'b1;
    pad = ~t.vec[0];
    for (int i = 0; i <= t.len + 2; i++) begin
      ro_in  = (i < t.len) ? t.vec[t.len-1-i] : pad;
      enable = (i >= 2);
      tick();
      if (i == 1) chk($sformatf("vec%0d_act_pre", idx), d1_act, 0);
      if (i == 2) chk($sformatf("vec%0d_act_on", idx), d1_act, 1);
    end
    enable = 1'b0;
    tick();
    chk($sformatf("vec%0d_act_off", idx), d1_act, 0);
    repeat (3) tick();
    chk($sformatf("vec%0d_nwords", idx), got.size(), t.nw);
    chk($sformatf("vec%0d_valid_cycles", idx), vcnt - v0, t.nw);
    if (t.nw >= 1) chk($sformatf("vec%0d_w0", idx), gw(0), {1'b0, t.w0});
    if (t.nw >= 2) chk($sformatf("vec%0d_w1", idx), gw(1), {1'b0, t.w1});
  endtask

  initial begin
    tbl[0] = '{64'h9A59,   16, 1, 8'hB2, 8'h00};
    tbl[1] = '{64'h878B59, 24, 1, 8'hB2, 8'h00};
    tbl[2] = '{64'hAAAA,   16, 1, 8'hFF, 8'h00};
    tbl[3] = '{64'h5555,   16, 1, 8'h00, 8'h00};
    tbl[4] = '{64'hAAAA5555, 32, 2, 8'hFF, 8'h00};
    tbl[5] = '{64'h2AAA,   14, 0, 8'h00, 8'h00};
    tbl[6] = '{64'h6666,   16, 1, 8'h55, 8'h00};

    // Reset with random inputs
    rst_n = 1'b0; enable = 1'b0; ro_in = 1'b0; rnd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable = 1'($urandom_range(0, 1)); ro_in = 1'($urandom_range(0, 1));
      rnd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_outputs_d1", {d1_act, d1_valid, d1_fault, d1_data}, 0);
    chk("rst_outputs_d4", {d4_act, d4_valid, d4_fault, d4_data}, 0);
    enable = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ro_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rel_outputs_d1", {d1_act, d1_valid, d1_fault, d1_data}, 0);
    chk("rel_outputs_d4", {d4_act, d4_valid, d4_fault, d4_data}, 0);

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Backpressure: word1 held, word2 parked in packer, word3 dropped, then word4 after release
    q_ro.delete();
    push_vec(64'hAAAA, 16); push_vec(64'h5555, 16); push_vec(64'h9A59, 16);
    push_fill(8); push_fill(8); push_vec(64'h6666, 16); push_fill(4);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < q_ro.size(); i++) begin
      ro_in = q_ro[i]; enable = (i >= 2); rnd_ready = (i >= 56);
      tick();
      if (i == 17) chk("bp_not_yet_valid", d1_valid, 0);
      if (i == 18) chk("bp_w1_valid", {d1_valid, d1_data}, {1'b1, 8'hFF});
      if (i == 50) chk("bp_w1_held", {d1_valid, d1_data}, {1'b1, 8'hFF});
      if (i == 55) chk("bp_no_handshake", got.size(), 0);
    end
    enable = 1'b0;
    repeat (3) tick();
    chk("bp_nwords", got.size(), 3);
    chk("bp_w1", gw(0), 9'h0FF);
    chk("bp_w2", gw(1), 9'h000);
    chk("bp_w4", gw(2), 9'h055);
    chk("bp_consecutive", gc(1) - gc(0), 1);

    // Health fault with a pending word
    rnd_ready = 1'b0;
    for (int i = 0; i <= 34; i++) begin
      logic [15:0] v;
      v = 16'h5555;
      ro_in = (i < 16) ? v[15-i] : 1'b0;
      enable = (i >= 2);
      tick();
      if (i == 18) chk("hf_pending", {d1_valid, d1_data}, {1'b1, 8'h00});
      if (i == 32) chk("hf_before", {d1_fault, d1_valid}, 2'b01);
      if (i == 33) chk("hf_set", {d1_fault, d1_valid, d1_act}, 3'b101);
      if (i == 34) chk("hf_act_off", {d1_act, d1_valid}, 2'b00);
    end
    enable = 1'b0; repeat (2) tick();
    enable = 1'b1; repeat (2) tick();
    chk("hf_sticky", {d1_fault, d1_act, d1_valid}, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("hf_reset_clears", {d1_fault, d1_act, d1_valid}, 3'b000);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Enable drop mid-word with a pending word
    q_ro.delete();
    push_vec(64'hAAAA, 16); push_vec(64'h155, 10); push_fill(4);
    push_vec(64'hA599, 16); push_fill(8);
    got.delete(); got_cyc.delete();
    for (int i = 0; i < q_ro.size(); i++) begin
      ro_in = q_ro[i];
      enable = (i >= 2 && i <= 27) || (i >= 32);
      rnd_ready = (i >= 50);
      tick();
      if (i == 29) chk("ed_pending_kept", {d1_valid, d1_act, d1_data}, {2'b10, 8'hFF});
    end
    enable = 1'b0;
    repeat (3) tick();
    chk("ed_nwords", got.size(), 2);
    chk("ed_w_old", gw(0), 9'h0FF);
    chk("ed_w_new", gw(1), 9'h0CA);
    chk("ed_consecutive", gc(1) - gc(0), 1);

    // Randomized run of the SAMPLE_DIV=4 instance against the model
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_reset();
    begin
      int mode = 0;
      for (int c = 0; c < 3600; c++) begin
        if (c == 1700) begin
          rst_n = 1'b0;
          #1;
          chk("async_rst_d4", {d4_act, d4_valid, d4_fault, d4_data}, 0);
          chk("async_rst_d1", {d1_act, d1_valid, d1_fault, d1_data}, 0);
          tick();
          rst_n = 1'b1;
          m_reset();
        end
        if (c % 256 == 0) mode = int'($urandom_range(0, 3));
        ro_in = (c >= 3200 && c < 3400) ? 1'b1 : 1'($urandom_range(0, 1));
        case (mode)
          0: rnd_ready = ($urandom_range(0, 3) != 0);
          1: rnd_ready = ($urandom_range(0, 9) == 0);
          2: rnd_ready = 1'b1;
          default: rnd_ready = 1'($urandom_range(0, 1));
        endcase
        enable = (mode == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 199) != 0);
        tick();
        m_step(enable, ro_in, rnd_ready);
        chk("rand_act", d4_act, m_act);
        chk("rand_valid", d4_valid, m_valid);
        chk("rand_fault", d4_fault, m_fault);
        chk("rand_data", d4_data, m_data);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
